// File: rtl/gf2_poly_reducer.sv
// gf2_poly_reducer: digit-serial reduction of a 2M-bit carry-less product modulo f(x) = x^M + R(x).
// D coefficients are cleared per clock from the top down; the M-bit remainder is registered on completion.
module gf2_poly_reducer #(
  parameter int           M = 384,
  parameter int           D = 8,
  parameter logic [M-1:0] R = 384'h100D
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*M-1:0] c_in,
  output logic           busy,
  output logic           done,
  output logic [M-1:0]   r_out
);

  localparam int STEPS = (D >= 1) ? (M / D) : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int AW    = $clog2(2 * M);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (D < 1 || (M % D) != 0) begin : g_bad_digit
      $error("gf2_poly_reducer: D must be >= 1 and divide M");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2*M-1:0]   acc;
  logic [2*M-1:0]   acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    top;

  // Chained single-bit steps: each folds x^p into x^(p-M)*R and sees the previous step's result.
  function automatic logic [2*M-1:0] reduce_digit(input logic [2*M-1:0] a,
                                                  input logic [AW-1:0]  hi);
    logic [2*M-1:0] v;
    logic [AW-1:0]  p;
    v = a;
    for (int i = 0; i < D; i++) begin
      p = hi - AW'(i);
      if (v[p]) begin
        v[p] = 1'b0;
        v[p - AW'(M) +: M] = v[p - AW'(M) +: M] ^ R;
      end
    end
    return v;
  endfunction

  assign top = AW'(2 * M - 1) - AW'(cnt) * AW'(D);

  always_comb begin
    acc_nxt = reduce_digit(acc, top);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      r_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            r_out <= acc_nxt[M-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          // Back-to-back: a start seen while done is high is accepted just as from IDLE.
          if (start) begin
            acc   <= c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_reducer.sv
// Randomized scoreboard bench for gf2_poly_reducer; the reference remainder is built from a table of x^k mod f.
module tb_gf2_poly_reducer;

  localparam int           M     = 384;
  localparam int           D     = 8;
  localparam logic [M-1:0] R     = 384'h100D;
  localparam int           LAT   = M / D + 1;
  localparam int           LIMIT = 4 * LAT;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*M-1:0] c_in;
  logic           busy;
  logic           done;
  logic [M-1:0]   r_out;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  logic [M-1:0] exp_q[$];
  logic [M-1:0] held;
  logic [M-1:0] pow_tab [2*M];

  always #5 clk = ~clk;

  gf2_poly_reducer #(.M(M), .D(D), .R(R)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .r_out (r_out)
  );

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // The remainder is linear in c: XOR together x^k mod f for every set coefficient k.
  function automatic logic [M-1:0] ref_mod(input logic [2*M-1:0] c);
    logic [M-1:0] r;
    r = '0;
    for (int k = 0; k < 2 * M; k++)
      if (c[k]) r = r ^ pow_tab[k];
    return r;
  endfunction

  function automatic logic [2*M-1:0] rand_poly();
    logic [2*M-1:0] v;
    for (int i = 0; i < 2 * M / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [2*M-1:0] c, input logic [M-1:0] e);
    start = 1'b1;
    c_in  = c;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int first, output int cyc);
    cyc = first;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles, required %0d", name, cyc, LAT);
    end
  endtask

  task automatic run_one(input string name, input logic [2*M-1:0] c, input logic [M-1:0] e);
    int cyc;
    issue(c, e);
    check({name, "_busy"}, M'(busy), M'(1));
    wait_done(name, 1, cyc);
    check_int({name, "_latency"}, cyc, LAT);
    check({name, "_busy_low"}, M'(busy), M'(0));
    @(negedge clk);
  endtask

  // Monitor: pops the expected remainder on every done pulse, otherwise checks that r_out holds.
  initial begin
    logic [M-1:0] e;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: r_out %h with no result pending", r_out);
        end else begin
          e = exp_q.pop_front();
          check("result", r_out, e);
          held = e;
        end
      end else begin
        check("r_out_hold", r_out, held);
      end
    end
  end

  initial begin
    logic [2*M-1:0] ca;
    logic [2*M-1:0] cb;
    logic [M-1:0]   t;
    logic [M-1:0]   e;
    logic           carry;
    int             cyc;
    int             dc;

    t = '0;
    t[0] = 1'b1;
    for (int k = 0; k < 2 * M; k++) begin
      pow_tab[k] = t;
      carry = t[M-1];
      t = t << 1;
      if (carry) t = t ^ R;
    end

    rst   = 1'b0;
    start = 1'b0;
    c_in  = '0;
    #1;
    check("reset_busy", M'(busy), M'(0));
    check("reset_done", M'(done), M'(0));
    check("reset_r_out", r_out, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_one("zero", '0, '0);

    ca = '0; ca[M-1] = 1'b1;
    e  = '0; e[M-1]  = 1'b1;
    run_one("x383", ca, e);

    ca = '0; ca[M] = 1'b1;
    run_one("x384", ca, 384'h100D);

    ca = '0; ca[2*M-1] = 1'b1;
    e  = 384'h80082E; e[M-1] = 1'b1;
    run_one("x767", ca, e);

    // Starts at cycles 5 and 20 of a run with different c_in must be ignored.
    ca = rand_poly();
    cb = rand_poly();
    dc = done_cnt;
    issue(ca, ref_mod(ca));
    repeat (4) @(negedge clk);
    start = 1'b1; c_in = cb;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; c_in = rand_poly();
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored", 21, cyc);
    check_int("ignored_latency", cyc, LAT);
    repeat (2 * LAT) @(negedge clk);
    check_int("ignored_done_count", done_cnt - dc, 1);

    // Asynchronous reset at cycle 30 aborts the run.
    ca = rand_poly();
    issue(ca, ref_mod(ca));
    repeat (29) @(negedge clk);
    check("abort_busy_before", M'(busy), M'(1));
    #2;
    held = '0;
    rst  = 1'b0;
    e    = exp_q.pop_back();
    #1;
    check("abort_busy", M'(busy), M'(0));
    check("abort_done", M'(done), M'(0));
    check("abort_r_out", r_out, '0);
    @(negedge clk);
    rst = 1'b1;
    dc  = done_cnt;
    repeat (2 * LAT) @(negedge clk);
    check_int("abort_no_done", done_cnt - dc, 0);

    // Start held high across DONE: second result exactly M/D+1 cycles after the first.
    ca = rand_poly();
    cb = rand_poly();
    start = 1'b1;
    c_in  = ca;
    exp_q.push_back(ref_mod(ca));
    wait_done("b2b_first", 0, cyc);
    check_int("b2b_first_latency", cyc, LAT);
    c_in = cb;
    exp_q.push_back(ref_mod(cb));
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second", 1, cyc);
    check_int("b2b_spacing", cyc, LAT);
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      ca = rand_poly();
      if (n % 3 == 2) ca[2*M-1 -: 32] = 32'hFFFF_FFFF;
      run_one("random", ca, ref_mod(ca));
    end

    repeat (3) @(negedge clk);
    check_int("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf2_poly_reducer.md
# gf2_poly_reducer

Sequential GF(2)[x] polynomial reducer that sits directly downstream of the four-way Toom-Cook carry-less multiplier. It consumes the 2M-bit unreduced product c and reduces it modulo f(x) = x^M + R(x). It processes D product bits per clock and returns the M-bit remainder with a start/busy/done handshake. The integrator asserts start once the multiplier's c output is stable for the operands of interest.

## Interface
- M, 384: field degree; remainder width. The input is 2M bits.
- D, 8: digit size, i.e. reduction steps unrolled per clock. M % D must be 0 and D ≥ 1; elaboration fails otherwise.
- R, 384'h100D: low part of f(x), with bit k being the coefficient of x^k. The default is f = x^384 + x^12 + x^3 + x^2 + 1. Irreducibility of f is the integrator's responsibility.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state immediately.
- start  input  1  request. Sampled on the rising edge only when the block is not busy.
- c_in  input  2M  unreduced carry-less product. Captured on the accepting edge.
- busy  output  1  high while the reduction is running.
- done  output  1  one-cycle pulse; r_out is valid while done=1 and afterwards.
- r_out  output  M  registered remainder c_in mod f. Held until the next completion.

## Operation
- Internal state: acc[2M-1:0], step counter cnt (width ceil(log2(M/D))), and a state register with states IDLE, RUN, DONE.
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, r_out=0, busy=0, done=0.
- IDLE:
  - If start=1: acc←c_in, cnt←0, go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge performs D sequential single-bit steps for positions p = 2M-1-cnt·D down to 2M-D-cnt·D.
  - Each step: if acc[p]=1, then acc[p]←0 and acc[p-M +: M] ^= R.
  - Steps within a cycle are chained, so each step sees the result of the previous one. This is exact for any R.
  - cnt←cnt+1.
  - On the edge where cnt = M/D-1: r_out←acc[M-1:0] taken after that edge's D steps, then go to DONE.
- DONE (one cycle): done=1, busy=0.
  - If start=1: accept the new c_in exactly as from IDLE and go to RUN. This is back-to-back operation.
  - Otherwise go to IDLE.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- start is ignored while busy=1. c_in changes during RUN have no effect.
- Bits of acc at or above position M are zero when the block enters DONE. Bits below M are never cleared, only XORed.
- Arithmetic is over GF(2) only: XOR, no carries.

## Timing
- Let E0 be the edge that samples start=1. RUN occupies edges E1..E(M/D). done is high in the cycle after edge E(M/D) and low again after E(M/D)+1.
- With the defaults this is 48 clocks from start to done.
- r_out changes only on the edge entering DONE. It holds its value through IDLE and through any subsequent RUN.
- Throughput is one reduction per M/D+1 clocks, reached when start is held or re-asserted in DONE.
- Reset mid-RUN aborts the operation. No done pulse is issued and r_out reads 0. Operation resumes on the first start after rst returns high.
- start and rst deasserting on the same edge: rst dominates while low. The first edge with rst=1 may accept start.

## Test plan
- c_in=0, start pulse → busy for 48 cycles, then done pulse with r_out=0.
- c_in = x^383 (bit 383 only) → r_out = bit 383 only; the input is unchanged because its degree is below M.
- c_in = x^384 → r_out = 384'h100D (equal to R).
- c_in = x^767 → r_out = x^383 + 384'h80082E (bits 383, 23, 11, 5, 3, 2, 1).
- Start pulses at cycles 5 and 20 of a run with a different c_in → the second start is ignored. One done pulse only; r_out matches the first c_in.
- rst low at cycle 30 of a run → busy, done and r_out go to 0 asynchronously with no done pulse. Then start held high across DONE → a second result arrives exactly M/D+1 cycles after the first done. Random c_in is checked against a software carry-less mod-f model.
